// File: rtl/dsm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dsm_pkg
// Description : Shared types and defaults for the upsampler / modulator path.
// Revision    : 1.0 - initial release
// ============================================================================
package dsm_pkg;

    localparam int c_DW_DEFAULT    = 20;
    localparam int c_RATIO_DEFAULT = 50;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    function automatic int ceil_log2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interp_upsampler_if.sv
`default_nettype none
// ============================================================================
// Interface   : interp_upsampler_if
// Description : Sample-in valid/ready port and per-clock sample-out port.
// Revision    : 1.0 - initial release
// ============================================================================
interface interp_upsampler_if
    import dsm_pkg::*;
#(
    parameter int DW = c_DW_DEFAULT
);
    logic                 linear;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_sos;
    logic                 underrun;

    modport master (
        output linear, in_valid, in_data,
        input  in_ready, out_valid, out_data, out_sos, underrun
    );

    modport slave (
        input  linear, in_valid, in_data,
        output in_ready, out_valid, out_data, out_sos, underrun
    );
endinterface
`default_nettype wire

// File: rtl/interp_seqdiv.sv
`default_nettype none
// ============================================================================
// Module      : interp_seqdiv
// Description : Restoring unsigned divider by constant RATIO, one bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module interp_seqdiv
    import dsm_pkg::*;
#(
    parameter int DW    = c_DW_DEFAULT,
    parameter int RATIO = c_RATIO_DEFAULT,
    parameter int PW    = ceil_log2(RATIO)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [PW-1:0] remainder
);
    localparam int          CW        = ceil_log2(DW + 1);
    localparam logic [PW:0] c_DIVISOR = (PW + 1)'(RATIO);

    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_rem;
    logic [DW-1:0] r_quo;

    logic [PW:0]   w_trial;
    logic          w_fits;

    // Dividend bits shift out of the top of r_quo while quotient bits shift in.
    assign w_trial = {r_rem, r_quo[DW-1]};
    assign w_fits  = (w_trial >= c_DIVISOR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= CW'(DW);
            r_rem  <= '0;
            r_quo  <= dividend;
        end else if (r_busy) begin
            r_rem <= PW'(w_fits ? (w_trial - c_DIVISOR) : w_trial);
            r_quo <= {r_quo[DW-2:0], w_fits};
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/interp_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : interp_upsampler
// Description : Linear / zero-order-hold upsampler, RATIO outputs per input.
// Revision    : 1.0 - initial release
// ============================================================================
module interp_upsampler
    import dsm_pkg::*;
#(
    parameter int DW    = c_DW_DEFAULT,
    parameter int RATIO = c_RATIO_DEFAULT,
    parameter int PW    = ceil_log2(RATIO)
) (
    input logic               clock,
    input logic               reset,
    interp_upsampler_if.slave bus
);
    localparam logic [PW:0]   c_RATIO_W    = (PW + 1)'(RATIO);
    localparam logic [PW-1:0] c_LAST_PHASE = PW'(RATIO - 1);

    state_t               r_state, w_state_nx;
    logic signed [DW-1:0] r_seg_end, w_seg_end_nx;
    logic signed [DW-1:0] r_nxt;
    logic                 r_nxt_full, w_nxt_full_nx;
    logic                 r_nxt_sgn;
    logic [DW-1:0]        r_q;
    logic [PW-1:0]        r_r;
    logic                 r_sgn;
    logic                 r_lin;
    logic [PW-1:0]        r_err, w_err_nx;
    logic [PW-1:0]        r_phase, w_phase_nx;
    logic                 r_out_valid, w_out_valid_nx;
    logic signed [DW-1:0] r_out_data, w_out_data_nx;
    logic                 r_out_sos, w_out_sos_nx;
    logic                 r_underrun, w_underrun_nx;

    logic                 w_accept, w_div_start, w_div_done, w_seg_ready, w_seg_start;
    logic signed [DW:0]   w_diff;
    logic [DW-1:0]        w_mag, w_div_q;
    logic [PW-1:0]        w_div_r;
    logic [PW:0]          w_err_sum;
    logic                 w_wrap;
    logic [DW:0]          w_inc;
    logic signed [DW-1:0] w_ramp;

    assign w_accept    = bus.in_valid && !r_nxt_full;
    assign w_div_start = w_accept && (r_state != ST_IDLE);
    assign w_diff      = {bus.in_data[DW-1], bus.in_data} - {r_seg_end[DW-1], r_seg_end};
    assign w_mag       = DW'(w_diff[DW] ? -w_diff : w_diff);
    assign w_seg_ready = r_nxt_full && w_div_done;

    interp_seqdiv #(.DW(DW), .RATIO(RATIO), .PW(PW)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (w_mag),
        .done      (w_div_done),
        .quotient  (w_div_q),
        .remainder (w_div_r)
    );

    // Bresenham: spread the remainder so cumulative offset is floor(|d|*k/RATIO).
    assign w_err_sum = {1'b0, r_err} + {1'b0, r_r};
    assign w_wrap    = (w_err_sum >= c_RATIO_W);
    assign w_inc     = {1'b0, r_q} + {{DW{1'b0}}, w_wrap};
    assign w_ramp    = DW'(r_sgn ? ({r_out_data[DW-1], r_out_data} - w_inc)
                                 : ({r_out_data[DW-1], r_out_data} + w_inc));

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_err_nx       = r_err;
        w_seg_end_nx   = r_seg_end;
        w_nxt_full_nx  = r_nxt_full;
        w_out_valid_nx = r_out_valid;
        w_out_data_nx  = r_out_data;
        w_out_sos_nx   = 1'b0;
        w_underrun_nx  = 1'b0;
        w_seg_start    = 1'b0;
        if (w_div_start) w_nxt_full_nx = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_out_valid_nx = 1'b0;
                if (w_accept) begin
                    w_seg_end_nx   = bus.in_data;
                    w_out_data_nx  = bus.in_data;
                    w_out_valid_nx = 1'b1;
                    w_state_nx     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_out_data_nx = r_seg_end;
                w_seg_start   = w_seg_ready;
            end
            ST_RUN: begin
                if (r_phase == c_LAST_PHASE) begin
                    if (w_seg_ready) begin
                        w_seg_start = 1'b1;
                    end else begin
                        w_underrun_nx = 1'b1;
                        w_state_nx    = ST_HOLD;
                        w_out_data_nx = r_seg_end;
                        w_phase_nx    = '0;
                    end
                end else begin
                    w_phase_nx = r_phase + 1'b1;
                    if (r_lin) begin
                        w_err_nx      = PW'(w_wrap ? (w_err_sum - c_RATIO_W) : w_err_sum);
                        w_out_data_nx = w_ramp;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
        // The start value is emitted from seg_end so every segment begins bit-exactly.
        if (w_seg_start) begin
            w_state_nx     = ST_RUN;
            w_phase_nx     = '0;
            w_err_nx       = '0;
            w_out_sos_nx   = 1'b1;
            w_out_valid_nx = 1'b1;
            w_out_data_nx  = r_seg_end;
            w_seg_end_nx   = r_nxt;
            w_nxt_full_nx  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_seg_end   <= '0;
            r_nxt       <= '0;
            r_nxt_full  <= 1'b0;
            r_nxt_sgn   <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_sgn       <= 1'b0;
            r_lin       <= 1'b0;
            r_err       <= '0;
            r_phase     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sos   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_seg_end   <= w_seg_end_nx;
            r_nxt_full  <= w_nxt_full_nx;
            r_err       <= w_err_nx;
            r_phase     <= w_phase_nx;
            r_out_valid <= w_out_valid_nx;
            r_out_data  <= w_out_data_nx;
            r_out_sos   <= w_out_sos_nx;
            r_underrun  <= w_underrun_nx;
            if (w_accept) begin
                r_nxt     <= bus.in_data;
                r_nxt_sgn <= w_diff[DW];
            end
            if (w_seg_start) begin
                r_q   <= w_div_q;
                r_r   <= w_div_r;
                r_sgn <= r_nxt_sgn;
                r_lin <= bus.linear;
            end
        end
    end

    assign bus.in_ready  = !r_nxt_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sos   = r_out_sos;
    assign bus.underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_interp_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_interp_upsampler
// Description : Randomised bench for interp_upsampler against a segment model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interp_upsampler;
    import dsm_pkg::*;

    localparam int DW     = c_DW_DEFAULT;
    localparam int RATIO  = c_RATIO_DEFAULT;
    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    interp_upsampler_if #(.DW(DW)) bus();

    interp_upsampler #(.DW(DW), .RATIO(RATIO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a segment from s to e at phase k sits at s + sign(d)*floor(|d|*k/RATIO).
    function automatic longint seg_value(input longint s, input longint e, input int k);
        longint d, mag, off;
        d   = e - s;
        mag = (d < 0) ? -d : d;
        off = (mag * k) / RATIO;
        return (d < 0) ? (s - off) : (s + off);
    endfunction

    typedef struct {
        logic signed [DW-1:0] val;
        int                   rdy;
    } pend_t;

    pend_t                pend[$];
    int                   cyc    = 0;
    int                   m_mode = M_IDLE;
    int                   m_k    = 0;
    logic signed [DW-1:0] m_start = '0;
    logic signed [DW-1:0] m_end   = '0;
    logic signed [DW-1:0] m_hold  = '0;
    bit                   m_lin   = 1'b0;
    bit                   m_urun  = 1'b0;
    bit                   chk_en  = 1'b0;

    task automatic begin_seg(input logic signed [DW-1:0] s);
        m_mode  = M_RUN;
        m_k     = 0;
        m_start = s;
        m_end   = pend[0].val;
        m_lin   = bus.linear;
        m_urun  = 1'b0;
        void'(pend.pop_front());
    endtask

    always @(negedge clock) begin : monitor
        longint e_data;
        bit     e_rdy;
        bit     acc;
        int     prev_mode;
        if (chk_en) begin
            e_rdy = (pend.size() == 0);
            case (m_mode)
                M_IDLE:  e_data = 0;
                M_HOLD:  e_data = m_hold;
                default: e_data = m_lin ? seg_value(m_start, m_end, m_k) : longint'(m_start);
            endcase
            check("in_ready",  bus.in_ready,  e_rdy);
            check("out_valid", bus.out_valid, m_mode != M_IDLE);
            check("out_data",  bus.out_data,  e_data);
            check("out_sos",   bus.out_sos,   (m_mode == M_RUN) && (m_k == 0));
            check("underrun",  bus.underrun,  (m_mode == M_HOLD) && m_urun);
            acc       = bus.in_valid && e_rdy;
            prev_mode = m_mode;
            if (reset) begin
                m_mode = M_IDLE;
                m_urun = 1'b0;
                pend.delete();
            end else begin
                case (m_mode)
                    M_IDLE: if (acc) begin
                        m_mode = M_HOLD;
                        m_hold = bus.in_data;
                        m_urun = 1'b0;
                    end
                    M_HOLD: begin
                        m_urun = 1'b0;
                        if (pend.size() > 0 && cyc >= pend[0].rdy) begin_seg(m_hold);
                    end
                    default: begin
                        if (m_k < RATIO - 1) begin
                            m_k++;
                        end else if (pend.size() > 0 && cyc >= pend[0].rdy) begin
                            begin_seg(m_end);
                        end else begin
                            m_mode = M_HOLD;
                            m_hold = m_end;
                            m_urun = 1'b1;
                        end
                    end
                endcase
                if (acc && prev_mode != M_IDLE) pend.push_back('{bus.in_data, cyc + DW + 1});
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic signed [DW-1:0] v);
        int n;
        n = 0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check("send_ready", bus.in_ready, 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_sos();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.out_sos && n < 400);
        if (!bus.out_sos) check("sos_wait", bus.out_sos, 1);
        @(posedge clock);
        #1;
    endtask

    function automatic logic signed [DW-1:0] rnd_sample(input logic signed [DW-1:0] prev);
        if ($urandom_range(0, 1) == 1) return DW'($urandom);
        return DW'(prev + $signed($urandom_range(0, 4000)) - 2000);
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic signed [DW-1:0] prev;
        prev         = '0;
        bus.linear   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);

        // Ramp, small negative step, full-scale swing, then random linear/hold mix.
        send(0);
        send(1000);
        send(0);
        send(-7);
        send(-524288);
        send(524287);
        prev = 524287;
        for (int i = 0; i < 6; i++) begin
            bus.linear = 1'($urandom_range(0, 1));
            prev = rnd_sample(prev);
            send(prev);
        end
        tick(130);
        prev = rnd_sample(prev);
        send(prev);
        tick(100);

        // Hold mode from a fresh reset; linear toggles mid-segment.
        reset = 1'b1;
        tick(2);
        reset      = 1'b0;
        bus.linear = 1'b0;
        send(5);
        send(900);
        wait_sos();
        tick(10);
        bus.linear = 1'b1;
        send(-300);
        wait_sos();
        tick(10);
        bus.linear = 1'b0;
        tick(100);

        // Random bursts with gaps long enough to cause underruns at times.
        prev = -300;
        for (int i = 0; i < 10; i++) begin
            bus.linear = 1'($urandom_range(0, 1));
            prev = rnd_sample(prev);
            send(prev);
            tick($urandom_range(0, 70));
        end
        tick(120);

        // Reset mid-segment at phase 23 with a sample buffered.
        bus.linear = 1'b1;
        send(111);
        send(-222);
        send(333);
        wait_sos();
        bus.in_data  = rnd_sample(prev);
        bus.in_valid = 1'b1;
        tick(1);
        bus.in_valid = 1'b0;
        tick(21);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);
        send(-1000);
        send(2000);
        tick(140);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
